// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-front-end definitions: reset address, NOP encoding, queue entry layout.
package ifetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: imem read channel plus the instruction stream toward decode.
interface ifetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
      output imem_gnt, imem_rvalid, imem_rdata, inst_ready
   );
endinterface

// File: rtl/ifetch_unit_fifo.sv
// Synchronous instruction queue of {pc, inst} entries with push/pop/flush and occupancy count.
module ifetch_unit_fifo
   import ifetch_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  fetch_entry_t               wdata,
   output fetch_entry_t               rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            // The issue rule reserves a slot for every live response.
            assert (!full);
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: sequential PC walk, imem read issue, response drop on redirect.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          DEPTH     = 4,
   parameter int          MAX_OUTST = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   ifetch_unit_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTST + 1);

   logic [31:0]   fetch_pc, resp_pc, stale_addr;
   logic [OW-1:0] outst, drop;
   logic          stale, req_q;

   logic [31:0]   fetch_pc_n, resp_pc_n, stale_addr_n;
   logic [OW-1:0] outst_n, drop_n;
   logic          stale_n, req_n;

   logic          grant, push, pop, empty;
   logic [CW-1:0] count;
   logic [31:0]   count_n, live_n;
   fetch_entry_t  push_entry, head;

   assign bus.imem_req   = req_q;
   assign bus.imem_addr  = stale ? stale_addr : fetch_pc;
   assign bus.inst_valid = !empty;
   assign bus.inst_data  = head.inst;
   assign bus.inst_pc    = head.pc;
   assign push_entry     = '{pc: resp_pc, inst: bus.imem_rdata};

   always_comb begin
      grant        = req_q && bus.imem_gnt;
      push         = bus.imem_rvalid && (drop == '0) && !redirect;
      pop          = !empty && bus.inst_ready && !redirect;
      outst_n      = outst + OW'(grant) - OW'(bus.imem_rvalid);
      fetch_pc_n   = fetch_pc;
      resp_pc_n    = resp_pc;
      stale_n      = stale;
      stale_addr_n = stale_addr;
      drop_n       = drop;
      if (redirect) begin
         // Every read still in flight after this cycle belongs to the old stream.
         fetch_pc_n = word_align(redirect_pc);
         resp_pc_n  = word_align(redirect_pc);
         drop_n     = outst_n;
         stale_n    = req_q && !bus.imem_gnt;
         if (req_q && !bus.imem_gnt) stale_addr_n = bus.imem_addr;
      end else begin
         if (grant) begin
            if (stale) begin
               stale_n = 1'b0;
               drop_n  = drop_n + OW'(1);
            end else begin
               fetch_pc_n = fetch_pc + 32'd4;
            end
         end
         if (bus.imem_rvalid && (drop != '0)) drop_n = drop_n - OW'(1);
         if (push) resp_pc_n = resp_pc + 32'd4;
      end
      count_n = redirect ? 32'd0 : (32'(count) + 32'(push) - 32'(pop));
      live_n  = 32'(outst_n) - 32'(drop_n);
      // Registered request: held until granted, otherwise raised only when a queue slot is free.
      req_n   = (req_q && !bus.imem_gnt) ||
                (!redirect && (32'(outst_n) < MAX_OUTST) && ((count_n + live_n) < DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc   <= RESET_PC;
         resp_pc    <= RESET_PC;
         stale_addr <= RESET_PC;
         outst      <= '0;
         drop       <= '0;
         stale      <= 1'b0;
         req_q      <= 1'b0;
      end else begin
         fetch_pc   <= fetch_pc_n;
         resp_pc    <= resp_pc_n;
         stale_addr <= stale_addr_n;
         outst      <= outst_n;
         drop       <= drop_n;
         stale      <= stale_n;
         req_q      <= req_n;
      end
   end

   ifetch_unit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata (push_entry),
      .rdata (head),
      .count (count),
      .empty (empty)
   );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: in-order imem model with configurable latency, decode-side logger.
module tb_ifetch_unit;
   import ifetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          lat = 1;
   logic [31:0] mq_addr [$];
   int          mq_due [$];
   logic [31:0] glog [$];
   logic [31:0] acc_pc [$];
   logic [31:0] acc_data [$];

   ifetch_unit_if bus();

   ifetch_unit #(.RESET_PC(32'h0), .DEPTH(4), .MAX_OUTST(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .bus         (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a << 8) | INST_NOP;
   endfunction

   function automatic logic [31:0] qget(input logic [31:0] q [$], input int i);
      return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   // Memory: records grants, returns words in order lat cycles later; decode: logs accepted heads.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         mq_addr.delete();
         mq_due.delete();
      end else begin
         if (bus.imem_req && bus.imem_gnt) begin
            mq_addr.push_back(bus.imem_addr);
            mq_due.push_back(cyc + lat - 1);
            glog.push_back(bus.imem_addr);
         end
         if (bus.inst_valid && bus.inst_ready && !redirect) begin
            acc_pc.push_back(bus.inst_pc);
            acc_data.push_back(bus.inst_data);
         end
      end
   end

   always @(negedge clk) begin
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = mem_word(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = '0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int l);
      rst          = 1'b1;
      redirect     = 1'b0;
      bus.imem_gnt = 1'b1;
      bus.inst_ready = 1'b1;
      lat          = l;
      @(negedge clk);
      acc_pc.delete();
      acc_data.delete();
      glog.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Sequential fetch, 1-cycle memory, decode always ready
      do_reset(1);
      chk("rst_req", bus.imem_req, 32'h0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      chk("rst_valid", bus.inst_valid, 32'h0);
      chk("rst_data", bus.inst_data, 32'h0);
      chk("rst_pc", bus.inst_pc, 32'h0);
      step();
      chk("t1_req", bus.imem_req, 32'h1);
      chk("t1_addr0", bus.imem_addr, 32'h0);
      step();
      chk("t1_addr1", bus.imem_addr, 32'h4);
      step();
      chk("t1_valid", bus.inst_valid, 32'h1);
      chk("t1_pc0", bus.inst_pc, 32'h0);
      chk("t1_data0", bus.inst_data, 32'h13);
      chk("t1_addr2", bus.imem_addr, 32'h8);
      step();
      chk("t1_pc1", bus.inst_pc, 32'h4);
      chk("t1_data1", bus.inst_data, 32'h413);
      step();
      chk("t1_pc2", bus.inst_pc, 32'h8);
      chk("t1_data2", bus.inst_data, 32'h813);

      // Decode stalls: queue fills to 4, fetch stops, head stable; then drains in order
      bus.inst_ready = 1'b0;
      step(2);
      chk("t2_req_off", bus.imem_req, 32'h0);
      step(4);
      chk("t2_req_still_off", bus.imem_req, 32'h0);
      chk("t2_valid", bus.inst_valid, 32'h1);
      chk("t2_pc_hold", bus.inst_pc, 32'h8);
      chk("t2_data_hold", bus.inst_data, 32'h813);
      chk("t2_grants", 32'(glog.size()), 32'd6);
      chk("t2_last_grant", qget(glog, 5), 32'h14);
      acc_pc.delete();
      acc_data.delete();
      bus.inst_ready = 1'b1;
      step(6);
      chk("t2_drained", 32'(acc_pc.size() >= 5), 32'h1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t2_pc%0d", i), qget(acc_pc, i), 32'h8 + 32'(4 * i));
         chk($sformatf("t2_data%0d", i), qget(acc_data, i), ((32'h8 + 32'(4 * i)) << 8) | 32'h13);
      end

      // Two reads in flight when redirecting to 0x100
      do_reset(3);
      step(3);
      chk("t3_req_full", bus.imem_req, 32'h0);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      chk("t3_valid", bus.inst_valid, 32'h0);
      chk("t3_req", bus.imem_req, 32'h0);
      step();
      chk("t3_req_new", bus.imem_req, 32'h1);
      chk("t3_addr_new", bus.imem_addr, 32'h100);
      step(8);
      chk("t3_first_pc", qget(acc_pc, 0), 32'h100);
      chk("t3_first_data", qget(acc_data, 0), 32'h10013);
      chk("t3_second_pc", qget(acc_pc, 1), 32'h104);
      chk("t3_grant_after", qget(glog, 2), 32'h100);

      // Request stuck without grant at 0x8 while redirecting to 0x40
      do_reset(1);
      step(3);
      chk("t4_addr_pre", bus.imem_addr, 32'h8);
      bus.imem_gnt = 1'b0;
      redirect     = 1'b1;
      redirect_pc  = 32'h40;
      step();
      redirect = 1'b0;
      chk("t4_valid", bus.inst_valid, 32'h0);
      chk("t4_req_hold0", bus.imem_req, 32'h1);
      chk("t4_addr_hold0", bus.imem_addr, 32'h8);
      step();
      chk("t4_addr_hold1", bus.imem_addr, 32'h8);
      step();
      chk("t4_addr_hold2", bus.imem_addr, 32'h8);
      bus.imem_gnt = 1'b1;
      step();
      chk("t4_req_next", bus.imem_req, 32'h1);
      chk("t4_addr_next", bus.imem_addr, 32'h40);
      step(2);
      chk("t4_valid_new", bus.inst_valid, 32'h1);
      chk("t4_pc_new", bus.inst_pc, 32'h40);
      chk("t4_data_new", bus.inst_data, 32'h4013);
      chk("t4_stale_grant", qget(glog, 2), 32'h8);
      chk("t4_new_grant", qget(glog, 3), 32'h40);

      // Redirect coinciding with a response and a pop
      do_reset(1);
      step(3);
      chk("t5_valid_pre", bus.inst_valid, 32'h1);
      chk("t5_pc_pre", bus.inst_pc, 32'h0);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      chk("t5_valid", bus.inst_valid, 32'h0);
      chk("t5_req", bus.imem_req, 32'h0);
      chk("t5_no_accept", 32'(acc_pc.size()), 32'd0);
      step();
      chk("t5_valid_still", bus.inst_valid, 32'h0);
      chk("t5_addr", bus.imem_addr, 32'h200);
      step(2);
      chk("t5_pc_new", bus.inst_pc, 32'h200);
      chk("t5_data_new", bus.inst_data, 32'h20013);

      // Unaligned redirect near the top of memory, wrap, then reset mid-stream
      do_reset(1);
      step();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      step();
      redirect = 1'b0;
      chk("t6_req_off", bus.imem_req, 32'h0);
      step();
      chk("t6_req", bus.imem_req, 32'h1);
      chk("t6_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
      step();
      chk("t6_addr_wrap", bus.imem_addr, 32'h0);
      step();
      chk("t6_pc_top", bus.inst_pc, 32'hFFFF_FFFC);
      chk("t6_data_top", bus.inst_data, 32'hFFFF_FC13);
      step();
      chk("t6_pc_wrap", bus.inst_pc, 32'h0);
      chk("t6_data_wrap", bus.inst_data, 32'h13);
      rst = 1'b1;
      step();
      chk("t6_rst_req", bus.imem_req, 32'h0);
      chk("t6_rst_addr", bus.imem_addr, 32'h0);
      chk("t6_rst_valid", bus.inst_valid, 32'h0);
      chk("t6_rst_data", bus.inst_data, 32'h0);
      chk("t6_rst_pc", bus.inst_pc, 32'h0);
      rst = 1'b0;
      step();
      chk("t6_restart_req", bus.imem_req, 32'h1);
      chk("t6_restart_addr", bus.imem_addr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
